regbank_v2: RTL and testbench

- Parametrised general-purpose register file for the datapath: two combinational read ports and one enabled write port.
- Configurable data width and register count; register 0 can be hardwired to zero.
- Adds a sequential bulk-clear engine: software or the controller can zero the whole file without a reset, at one entry per cycle, with busy/done handshake.

---
 rtl/regbank_v2.sv | 123 ++++++++++++
 tb/tb_regbank_v2.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/regbank_v2.sv
// Register file with two combinational read ports, one write port and a one-entry-per-cycle bulk-clear sweep.
// Optional macro REGBANK_WR_BYPASS_EN forwards the write data to a read port that addresses the same entry.

module regbank_v2_rdport #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic [DW-1:0] stored,
    input  logic [AW-1:0] sr,
    input  logic          fwd,
    input  logic [DW-1:0] wrData,
    output logic [DW-1:0] rd
);
    // The zero-register force wins over forwarding.
    always_comb begin
        if (ZERO_REG != 0 && sr == '0) rd = '0;
        else if (fwd)                  rd = wrData;
        else                           rd = stored;
    end
endmodule

module regbank_v2 #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] dr,
    input  logic [DW-1:0] wrData,
    input  logic [AW-1:0] sr1,
    input  logic [AW-1:0] sr2,
    output logic [DW-1:0] rdData1,
    output logic [DW-1:0] rdData2,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          wr_drop
);
    localparam int DEPTH = 1 << AW;
    localparam int NRD   = 2;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] ptr, ptr_nxt;
    logic          done_nxt;
    logic [DW-1:0] mem [DEPTH];
    logic          wr_ok;

    assign clr_busy = (state == CLEAR);
    assign wr_drop  = wr_en & (clr_busy | ((ZERO_REG != 0) && (dr == '0)));
    assign wr_ok    = wr_en & ~wr_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            clr_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        done_nxt  = 1'b0;
        case (state)
            IDLE: if (clr_req) begin
                state_nxt = CLEAR;
                ptr_nxt   = '0;
            end
            CLEAR: begin
                // Pointer wraps naturally to 0 after the last entry.
                ptr_nxt = ptr + 1'b1;
                if (ptr == AW'(DEPTH - 1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr_busy) begin
            mem[ptr] <= '0;
        end else if (wr_ok) begin
            mem[dr] <= wrData;
        end
    end

    logic [NRD-1:0][AW-1:0] sr_v;
    logic [NRD-1:0][DW-1:0] rd_v;
    logic [NRD-1:0]         fwd_v;

    assign sr_v = {sr2, sr1};

    for (genvar p = 0; p < NRD; p++) begin : g_rd
`ifdef REGBANK_WR_BYPASS_EN
        assign fwd_v[p] = wr_ok && (dr == sr_v[p]);
`else
        assign fwd_v[p] = 1'b0;
`endif
        regbank_v2_rdport #(.DW(DW), .AW(AW), .ZERO_REG(ZERO_REG)) u_rd (
            .stored (mem[sr_v[p]]),
            .sr     (sr_v[p]),
            .fwd    (fwd_v[p]),
            .wrData (wrData),
            .rd     (rd_v[p])
        );
    end

    assign rdData1 = rd_v[0];
    assign rdData2 = rd_v[1];
endmodule

// File: tb/tb_regbank_v2.sv
// Directed bench for regbank_v2: one ZERO_REG=1 and one ZERO_REG=0 instance sharing the same stimulus.

module tb_regbank_v2;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [4:0]  dr = '0, sr1 = '0, sr2 = '0;
    logic [31:0] wrData = '0;
    logic        clr_req = 1'b0;

    logic [31:0] rd1, rd2, rd1_z, rd2_z;
    logic        busy, done, drop, busy_z, done_z, drop_z;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regbank_v2 #(.DW(32), .AW(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .dr(dr), .wrData(wrData),
        .sr1(sr1), .sr2(sr2), .rdData1(rd1), .rdData2(rd2),
        .clr_req(clr_req), .clr_busy(busy), .clr_done(done), .wr_drop(drop)
    );

    regbank_v2 #(.DW(32), .AW(5), .ZERO_REG(0)) dut_z (
        .clk(clk), .rst(rst), .wr_en(wr_en), .dr(dr), .wrData(wrData),
        .sr1(sr1), .sr2(sr2), .rdData1(rd1_z), .rdData2(rd2_z),
        .clr_req(clr_req), .clr_busy(busy_z), .clr_done(done_z), .wr_drop(drop_z)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1; dr = a; wrData = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        #12 rst = 1'b0;
        tick();

        // reset with live contents, asserted mid-cycle
        wr(5'd3, 32'h1111_2222);
        wr(5'd9, $urandom | 32'h1);
        sr1 = 5'd3; sr2 = 5'd9; #1;
        chk("pre_rst_r3", rd1, 32'h1111_2222);
        #2 rst = 1'b1; #1;
        chk("rst_rd1", rd1, 32'h0);
        chk("rst_rd2", rd2, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        #2 rst = 1'b0;
        tick();

        // basic write/read, both ports
        wr(5'd7, 32'hDEAD_BEEF);
        wr(5'd31, 32'h1234_5678);
        sr1 = 5'd7; sr2 = 5'd31; #1;
        chk("basic_rd1", rd1, 32'hDEAD_BEEF);
        chk("basic_rd2", rd2, 32'h1234_5678);
        sr2 = 5'd7; #1;
        chk("same_entry_rd2", rd2, 32'hDEAD_BEEF);

        // zero register
        wr_en = 1'b1; dr = 5'd0; wrData = 32'hFFFF_FFFF; #1;
        chk("zr_drop", {31'b0, drop}, 32'h1);
        chk("zr0_drop", {31'b0, drop_z}, 32'h0);
        tick();
        wr_en = 1'b0; sr1 = 5'd0; #1;
        chk("zr_rd", rd1, 32'h0);
        chk("zr0_rd", rd1_z, 32'hFFFF_FFFF);

        // bulk clear with r20 observation and a dropped write mid-sweep
        for (int i = 0; i < 32; i++) wr(5'(i), 32'(i + 1));
        sr1 = 5'd20; sr2 = 5'd31; #1;
        chk("fill_r31", rd2, 32'd32);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 34; k++) begin
            chk($sformatf("sw_busy_%0d", k), {31'b0, busy}, {31'b0, k < 32});
            chk($sformatf("sw_done_%0d", k), {31'b0, done}, {31'b0, k == 32});
            if (k == 20 || k == 21)
                chk($sformatf("sw_r20_%0d", k), rd1, (k < 21) ? 32'd21 : 32'd0);
            if (k == 5) begin
                wr_en = 1'b1; dr = 5'd31; wrData = 32'hA5A5_A5A5; #1;
                chk("sw_wr_drop", {31'b0, drop}, 32'h1);
                chk("sw_wr_drop_z", {31'b0, drop_z}, 32'h1);
            end
            tick();
            wr_en = 1'b0;
        end
        for (int i = 0; i < 32; i++) begin
            sr1 = 5'(i); #1;
            chk($sformatf("clr_r%0d", i), rd1_z, 32'h0);
        end
        sr2 = 5'd31; #1;
        chk("clr_r31_drop", rd2, 32'h0);

        // reset during the 10th sweep cycle
        wr(5'd31, 32'hCAFE_0031);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (9) tick();
        chk("msw_busy_before", {31'b0, busy}, 32'h1);
        #2 rst = 1'b1; #1;
        chk("msw_busy", {31'b0, busy}, 32'h0);
        chk("msw_r31", rd2, 32'h0);
        #2 rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done || busy) begin
                chk("msw_no_done", {30'b0, busy, done}, 32'h0);
                break;
            end
        end
        chk("msw_idle", {30'b0, busy, done}, 32'h0);

        // write-to-read forwarding
        wr(5'd5, 32'h1);
        wr_en = 1'b1; dr = 5'd5; wrData = 32'h55AA_55AA; sr1 = 5'd5; #1;
`ifdef REGBANK_WR_BYPASS_EN
        chk("byp_same", rd1, 32'h55AA_55AA);
`else
        chk("byp_same", rd1, 32'h1);
`endif
        tick();
        wr_en = 1'b0; #1;
        chk("byp_next", rd1, 32'h55AA_55AA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end, want finish");
        $fatal(1);
    end
endmodule
